alu_exec_ctrl: RTL
==================

// Module: alu_exec_ctrl
// PURPOSE
//  Sequences one ARM data-processing instruction at a time through the shared
//  combinational ALU. Owns the NZCV flags register and evaluates the condition
//  field against it. Registers the ALU result, then drives register-file write-back
//  and the PC-load/flush request. Sits between decode/operand-fetch (upstream) and
//  the ALU / register file / fetch unit.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset ({N,Z,C,V} = bits 3..0)
//  PC_REG       4'd15    register index that triggers pc_load on write-back
//  CNT_W        16       width of retired/skipped counters (saturating)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      upstream holds a decoded DP instruction
//  in_ready     out  1      controller can accept (high only in IDLE, low while reset)
//  in_cond      in   4      condition field (EQ=0 .. AL=14, NV=15)
//  in_opcode    in   4      DP opcode (AND=0 .. MVN=15, ARM encoding)
//  in_s         in   1      S bit
//  in_rd        in   4      destination register
//  in_opa       in   32     Rn value
//  in_opb       in   32     shifted operand 2
//  in_shcarry   in   1      shifter carry-out, used as C for logical ops
//  alu_opcode   out  4      to ALU
//  alu_setflags out  1      to ALU
//  alu_a        out  32     to ALU
//  alu_b        out  32     to ALU
//  alu_flagsin  out  4      to ALU (= flags)
//  alu_wb       in   1      ALU writeback indication
//  alu_result   in   32     ALU dataout
//  alu_flags    in   4      ALU flagsout
//  rf_we        out  1      register-file write strobe (1 cycle)
//  rf_waddr     out  4      write address
//  rf_wdata     out  32     write data
//  pc_load      out  1      1-cycle pulse: load pc_value into PC, flush fetch
//  pc_value     out  32     new PC (result with bits [1:0] forced 0)
//  flags        out  4      current NZCV
//  done         out  1      1-cycle pulse when instruction retires or is skipped
//  skipped      out  1      valid with done: condition failed
//  retired_cnt  out  CNT_W  instructions executed (cond passed)
//  skipped_cnt  out  CNT_W  instructions skipped
// BEHAVIOUR
//  Reset: state=IDLE, flags=RESET_FLAGS, counters=0. All strobes, alu_* and rf_*
//   outputs =0. in_ready=0 while reset is high.
//  IDLE: in_ready=1. in_valid&in_ready -> capture all in_* fields, go EXEC.
//  EXEC: alu_* driven from captured regs; alu_setflags=captured S. Evaluate cond
//   on flags:
//   - HI = C&~Z; LS = ~C|Z; GE = N==V; GT = ~Z&(N==V); LE = Z|(N!=V).
//   - AL always passes; NV never passes.
//   - Fail -> done=1, skipped=1, skipped_cnt++, no write, no flag change, go IDLE.
//   - Pass -> register alu_result, alu_wb, alu_flags, go WB.
//  WB (1 cycle):
//   - Write-back: rf_we=alu_wb_q, rf_waddr=rd, rf_wdata=result.
//   - Flag update: when S or opcode in {TST,TEQ,CMP,CMN}, flags<=alu_flags_q, except
//     logical ops {AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN}: C<=shcarry_q, V unchanged.
//   - Flag update takes effect at the end of WB.
//   - done=1, skipped=0, retired_cnt++.
//   - If alu_wb_q & rd==PC_REG: pc_load=1, pc_value={result[31:2],2'b00}; go FLUSH.
//   - Else go IDLE.
//  FLUSH (1 cycle): in_ready=0, no outputs asserted; go IDLE (upstream discards).
//  Latency:
//   - Accept at edge T; EXEC in cycle T+1; WB strobes in cycle T+2; FLUSH in T+3
//     when taken.
//   - Next accept earliest at edge T+3 (T+4 after FLUSH), so the next EXEC always
//     sees updated flags.
//  Counters saturate at all-ones; no wrap.
//  Upstream must hold in_* stable only until the accept edge.
//  Reset in any state aborts: no rf_we/pc_load/done is issued in the reset cycle
//   or after it.
// TESTING
//  1 Reset, then ADDS r1: opa=7, opb=5, AL -> EXEC T+1; T+2: rf_we=1, waddr=1,
//    wdata=12, flags=0000 after WB, done=1, retired_cnt=1.
//  2 CMP opa=3, opb=3 with cond=AL, then MOVEQ r2,#9 -> CMP: rf_we=0, Z=1;
//    MOVEQ: rf_we=1, wdata=9.
//  3 Flags=0000, ADDNE vs ADDEQ -> NE retires; EQ gives done=1, skipped=1, no
//    rf_we, skipped_cnt=1, flags unchanged.
//  4 MOVS r0, opb=0, shcarry=1 -> flags N=0, Z=1, C=1, V unchanged.
//  5 MOV r15, opb=0x0000_1003 -> pc_load=1, pc_value=0x0000_1000, in_ready=0
//    for FLUSH, then 1.
//  6 Reset asserted in WB cycle of an ADD -> no rf_we; flags=RESET_FLAGS,
//    in_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: runs one ARM data-processing instruction through the
// shared ALU, owns NZCV, evaluates the condition field and issues write-back / PC load.
module alu_exec_ctrl #(
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter logic [3:0]  PC_REG      = 4'd15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_opcode,
    input  logic             in_s,
    input  logic [3:0]       in_rd,
    input  logic [31:0]      in_opa,
    input  logic [31:0]      in_opb,
    input  logic             in_shcarry,
    output logic [3:0]       alu_opcode,
    output logic             alu_setflags,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_flagsin,
    input  logic             alu_wb,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             pc_load,
    output logic [31:0]      pc_value,
    output logic [3:0]       flags,
    output logic             done,
    output logic             skipped,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] skipped_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, FLUSH} state_t;

    state_t state, next_state;

    logic [3:0]  cond_q, opcode_q, rd_q;
    logic        s_q, shcarry_q;
    logic [31:0] opa_q, opb_q;
    logic [31:0] result_q;
    logic        wb_q;
    logic [3:0]  aflags_q;

    logic accept, cond_pass, pc_hit, is_test, is_logical;
    logic n_f, z_f, c_f, v_f;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign {n_f, z_f, c_f, v_f} = flags;
    assign accept  = in_valid && in_ready;
    assign pc_hit  = wb_q && (rd_q == PC_REG);
    assign is_test = (opcode_q[3:2] == 2'b10);

    always_comb begin
        case (opcode_q)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15: is_logical = 1'b1;
            default:                                             is_logical = 1'b0;
        endcase
    end

    always_comb begin
        case (cond_q)
            4'd0:    cond_pass = z_f;
            4'd1:    cond_pass = !z_f;
            4'd2:    cond_pass = c_f;
            4'd3:    cond_pass = !c_f;
            4'd4:    cond_pass = n_f;
            4'd5:    cond_pass = !n_f;
            4'd6:    cond_pass = v_f;
            4'd7:    cond_pass = !v_f;
            4'd8:    cond_pass = c_f && !z_f;
            4'd9:    cond_pass = !c_f || z_f;
            4'd10:   cond_pass = (n_f == v_f);
            4'd11:   cond_pass = (n_f != v_f);
            4'd12:   cond_pass = !z_f && (n_f == v_f);
            4'd13:   cond_pass = z_f || (n_f != v_f);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = cond_pass ? WB : IDLE;
            WB:      next_state = pc_hit ? FLUSH : IDLE;
            FLUSH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= RESET_FLAGS;
            retired_cnt <= '0;
            skipped_cnt <= '0;
            cond_q      <= '0;
            opcode_q    <= '0;
            rd_q        <= '0;
            s_q         <= 1'b0;
            shcarry_q   <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            wb_q        <= 1'b0;
            aflags_q    <= '0;
        end else begin
            if (accept) begin
                cond_q    <= in_cond;
                opcode_q  <= in_opcode;
                s_q       <= in_s;
                rd_q      <= in_rd;
                opa_q     <= in_opa;
                opb_q     <= in_opb;
                shcarry_q <= in_shcarry;
            end
            if (state == EXEC) begin
                if (cond_pass) begin
                    result_q <= alu_result;
                    wb_q     <= alu_wb;
                    aflags_q <= alu_flags;
                end else if (skipped_cnt != '1) begin
                    skipped_cnt <= skipped_cnt + CNT_ONE;
                end
            end
            if (state == WB) begin
                // Logical ops take C from the shifter and leave V untouched.
                if (s_q || is_test) begin
                    if (is_logical) flags <= {aflags_q[3:2], shcarry_q, flags[0]};
                    else            flags <= aflags_q;
                end
                if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_ONE;
            end
        end
    end

    // Every strobe is masked by reset so an aborted instruction never leaks out.
    always_comb begin
        in_ready     = (state == IDLE) && !reset;
        alu_opcode   = '0;
        alu_setflags = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_flagsin  = flags;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        pc_load      = 1'b0;
        pc_value     = '0;
        done         = 1'b0;
        skipped      = 1'b0;
        if (!reset) begin
            case (state)
                EXEC: begin
                    alu_opcode   = opcode_q;
                    alu_setflags = s_q;
                    alu_a        = opa_q;
                    alu_b        = opb_q;
                    if (!cond_pass) begin
                        done    = 1'b1;
                        skipped = 1'b1;
                    end
                end
                WB: begin
                    rf_we    = wb_q;
                    rf_waddr = rd_q;
                    rf_wdata = result_q;
                    done     = 1'b1;
                    if (pc_hit) begin
                        pc_load  = 1'b1;
                        pc_value = {result_q[31:2], 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
